// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: filters SCL/SDA, decodes START/ADDR/DATA/STOP into an Avalon-MM FIFO log.
// Optional level interrupt is built in when I2C_MON_IRQ_EN is defined.
module i2c_bus_monitor #(
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned LOG_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int unsigned AW = $clog2(LOG_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {StIdle, StAddr, StAddrAck, StData, StDataAck} state_e;

  // Line vectors: bit 0 is SCL, bit 1 is SDA.
  logic [1:0]    raw, sync1_q, sync2_q, filt_q, filt_prev_q;
  logic [3:0]    fcnt_q [2];
  logic          scl_f, sda_f, start_cond, stop_cond, scl_rise;

  state_e        state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic          push_q;
  logic [10:0]   push_data_q;
  logic          frame_inc_q;

  logic [10:0]   mem_q [LOG_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [6:0]    count7;
  logic          empty, full, push_ok, pop, busy;
  logic          wr_en, rd_en, log_rd, rd_prev_q;
  logic          overflow_q, enable_q, irq_en;
  logic [15:0]   frames_q;
  logic          unused_wdata;

  assign raw = {sda_in, scl_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      filt_prev_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      filt_prev_q <= filt_q;
      // Counter tracks consecutive samples that disagree with the filtered level.
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == 4'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign scl_f      = filt_q[0];
  assign sda_f      = filt_q[1];
  assign start_cond = scl_f && filt_prev_q[0] && filt_prev_q[1] && !sda_f;
  assign stop_cond  = scl_f && filt_prev_q[0] && !filt_prev_q[1] && sda_f;
  assign scl_rise   = scl_f && !filt_prev_q[0];
  assign busy       = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      frame_inc_q <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_inc_q <= 1'b0;
      if (!enable_q) begin
        state_q <= StIdle;
      end else if (stop_cond) begin
        push_q      <= 1'b1;
        push_data_q <= {2'b11, 9'b0};
        frame_inc_q <= 1'b1;
        state_q     <= StIdle;
      end else if (start_cond) begin
        push_q      <= 1'b1;
        push_data_q <= {2'b00, 9'b0};
        bit_cnt_q   <= '0;
        state_q     <= StAddr;
      end else if (scl_rise) begin
        unique case (state_q)
          StAddr, StData: begin
            shift_q   <= {shift_q[6:0], sda_f};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= (state_q == StAddr) ? StAddrAck : StDataAck;
          end
          StAddrAck, StDataAck: begin
            push_q      <= 1'b1;
            push_data_q <= {(state_q == StAddrAck) ? 2'b01 : 2'b10, sda_f, shift_q};
            bit_cnt_q   <= '0;
            state_q     <= StData;
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_en   = chipselect && write;
  assign rd_en   = chipselect && read;
  assign log_rd  = rd_en && (address == 2'd0);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(LOG_DEPTH));
  assign pop     = log_rd && !rd_prev_q && !empty;
  assign push_ok = push_q && (!full || pop);
  assign count7  = 7'(count_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_prev_q  <= 1'b0;
      overflow_q <= 1'b0;
      enable_q   <= 1'b0;
      frames_q   <= '0;
    end else begin
      rd_prev_q <= log_rd;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop) count_q <= count_q + CW'(1);
      else if (!push_ok && pop) count_q <= count_q - CW'(1);
      if (wr_en && address == 2'd1 && writedata[10]) overflow_q <= 1'b0;
      // A dropped entry wins over a same-cycle clear so no overflow goes unreported.
      if (push_q && full && !pop) overflow_q <= 1'b1;
      if (wr_en && address == 2'd2) enable_q <= writedata[0];
      if (wr_en && address == 2'd3) frames_q <= '0;
      else if (frame_inc_q) frames_q <= frames_q + 16'd1;
    end
  end

`ifdef I2C_MON_IRQ_EN
  logic irq_en_q, irq_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en && address == 2'd2) irq_en_q <= writedata[1];
      irq_q <= irq_en_q && (!empty || overflow_q);
    end
  end
  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    if (rd_en) begin
      case (address)
        2'd0:    if (!empty) readdata = {1'b1, 20'b0, mem_q[rd_ptr_q]};
        2'd1:    readdata = {18'b0, sda_f, scl_f, busy, overflow_q, full, empty, 1'b0, count7};
        2'd2:    readdata = {30'b0, irq_en, enable_q};
        default: readdata = {16'b0, frames_q};
      endcase
    end
  end

  // Write-data bits that no register decodes.
  assign unused_wdata = ^{writedata[31:11], writedata[9:1]};

endmodule
